// File: rtl/jk_reg_bank.sv
// jk_reg_bank: bank of WIDTH JK bit-cells with four operating modes.
//   mode 00 JK    : per-bit hold / clear / set / toggle from {j,k}
//   mode 01 LOAD  : parallel load from d
//   mode 10 COUNT : binary up-count, co flags the all-ones -> 0 wrap
//   mode 11 SHIFT : shift left, si enters at bit 0
// q, co and chg are registered. qb is the combinational complement of q.
// Optional feature: define JK_REG_BANK_TCNT_EN to add the 16-bit saturating
// output tcnt. It counts the enabled JK-mode edges on which at least one bit
// toggled.
module jk_reg_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
`ifdef JK_REG_BANK_TCNT_EN
    output logic [15:0]      tcnt,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             co,
    output logic             chg
);

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_COUNT = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    logic [WIDTH-1:0] q_r;
    logic             co_r;
    logic             chg_r;
    logic [WIDTH-1:0] next_q_s;
    logic             next_co_s;
    logic [WIDTH:0]   count_s;
    logic [WIDTH-1:0] shift_s;

    // Incrementer with an extra bit so the wrap carry falls out directly.
    assign count_s = {1'b0, q_r} + {{WIDTH{1'b0}}, 1'b1};

    // A single-bit bank has no upper bits to keep, so shifting just loads si.
    generate
        if (WIDTH == 1) begin : g_shift_one
            assign shift_s = si;
        end else begin : g_shift_many
            assign shift_s = {q_r[WIDTH-2:0], si};
        end
    endgenerate

    // Next-state selection. JK uses the characteristic equation
    // q+ = (j & ~q) | (~k & q), evaluated from the registered q only, so a
    // toggle cannot feed back on itself within a cycle.
    always_comb begin
        next_q_s  = q_r;
        next_co_s = 1'b0;
        case (mode)
            MODE_JK: begin
                next_q_s = (j & ~q_r) | (~k & q_r);
            end
            MODE_LOAD: begin
                next_q_s = d;
            end
            MODE_COUNT: begin
                next_q_s  = count_s[WIDTH-1:0];
                next_co_s = count_s[WIDTH];
            end
            MODE_SHIFT: begin
                next_q_s = shift_s;
            end
            default: begin
                next_q_s  = q_r;
                next_co_s = 1'b0;
            end
        endcase
    end

    // State register. Reset wins over en and mode. When en is low, q holds
    // and both one-cycle flags drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r   <= RST_VAL;
            co_r  <= 1'b0;
            chg_r <= 1'b0;
        end else if (en) begin
            q_r   <= next_q_s;
            co_r  <= next_co_s;
            chg_r <= (next_q_s != q_r);
        end else begin
            q_r   <= q_r;
            co_r  <= 1'b0;
            chg_r <= 1'b0;
        end
    end

`ifdef JK_REG_BANK_TCNT_EN
    logic [15:0] tcnt_r;
    logic        toggle_hit_s;

    // A toggle happens on a JK edge when any bit has both j and k high.
    assign toggle_hit_s = en && (mode == MODE_JK) && (|(j & k));

    // Saturating toggle-edge counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_r <= 16'h0000;
        end else if (toggle_hit_s && (tcnt_r != 16'hFFFF)) begin
            tcnt_r <= tcnt_r + 16'h0001;
        end else begin
            tcnt_r <= tcnt_r;
        end
    end

    assign tcnt = tcnt_r;
`endif

    assign q   = q_r;
    assign qb  = ~q_r;
    assign co  = co_r;
    assign chg = chg_r;

endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank: directed, self-checking bench for jk_reg_bank.
// WIDTH = 8 and RST_VAL = 8'hA5. Inputs change 1 ns after a rising edge, and
// outputs are sampled at that same point.
module tb_jk_reg_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] d;
    logic       si;
    logic [7:0] q;
    logic [7:0] qb;
    logic       co;
    logic       chg;
`ifdef JK_REG_BANK_TCNT_EN
    logic [15:0] tcnt;
`endif

    int checks = 0;
    int errors = 0;

    jk_reg_bank #(.WIDTH(8), .RST_VAL(8'hA5)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .j    (j),
        .k    (k),
        .d    (d),
        .si   (si),
`ifdef JK_REG_BANK_TCNT_EN
        .tcnt (tcnt),
`endif
        .q    (q),
        .qb   (qb),
        .co   (co),
        .chg  (chg)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eq, input logic eco, input logic echg);
        chk({tag, ".q"},   {24'h0, q},   {24'h0, eq});
        chk({tag, ".qb"},  {24'h0, qb},  {24'h0, ~eq});
        chk({tag, ".co"},  {31'h0, co},  {31'h0, eco});
        chk({tag, ".chg"}, {31'h0, chg}, {31'h0, echg});
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00;
        j = 8'h00; k = 8'h00; d = 8'h00; si = 1'b0;

        // reset
        tick();
        chk_all("reset", 8'hA5, 1'b0, 1'b0);

        // load 00 so the JK sequence starts from zero
        rst = 1'b0; en = 1'b1; mode = 2'b01; d = 8'h00;
        tick();
        chk_all("load00", 8'h00, 1'b0, 1'b1);

        // JK mode
        mode = 2'b00; j = 8'hF0; k = 8'h0F; d = 8'h77;
        tick();
        chk_all("jk_set", 8'hF0, 1'b0, 1'b1);
        j = 8'hFF; k = 8'hFF;
        tick();
        chk_all("jk_toggle", 8'h0F, 1'b0, 1'b1);
        j = 8'h00; k = 8'h00;
        tick();
        chk_all("jk_hold", 8'h0F, 1'b0, 1'b0);
        j = 8'h3C; k = 8'hC3;
        tick();
        chk_all("jk_mixed", 8'h3C, 1'b0, 1'b1);

        // LOAD then COUNT across the wrap
        mode = 2'b01; d = 8'hFE; j = 8'hFF; k = 8'h00;
        tick();
        chk_all("load_fe", 8'hFE, 1'b0, 1'b1);
        mode = 2'b10; d = 8'h00;
        tick();
        chk_all("cnt_ff", 8'hFF, 1'b0, 1'b1);
        tick();
        chk_all("cnt_wrap", 8'h00, 1'b1, 1'b1);
        tick();
        chk_all("cnt_01", 8'h01, 1'b0, 1'b1);

        // co drops in a non-COUNT mode right after a wrap
        mode = 2'b01; d = 8'hFF;
        tick();
        mode = 2'b10;
        tick();
        chk_all("wrap2", 8'h00, 1'b1, 1'b1);
        mode = 2'b01; d = 8'h00;
        tick();
        chk_all("load_same", 8'h00, 1'b0, 1'b0);

        // SHIFT, then en=0 holds
        d = 8'h81;
        tick();
        chk_all("load_81", 8'h81, 1'b0, 1'b1);
        mode = 2'b11; si = 1'b1;
        tick();
        chk_all("shift1", 8'h03, 1'b0, 1'b1);
        si = 1'b0;
        tick();
        chk_all("shift0", 8'h06, 1'b0, 1'b1);
        en = 1'b0; si = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("en_hold", 8'h06, 1'b0, 1'b0);
        end

        // en=0 also clears a pending co
        en = 1'b1; mode = 2'b01; d = 8'hFF;
        tick();
        mode = 2'b10;
        tick();
        chk_all("wrap3", 8'h00, 1'b1, 1'b1);
        en = 1'b0;
        tick();
        chk_all("en_clr_co", 8'h00, 1'b0, 1'b0);

        // reset in the middle of a count, then resume
        en = 1'b1; mode = 2'b01; d = 8'h10;
        tick();
        mode = 2'b10;
        tick();
        chk_all("cnt_11", 8'h11, 1'b0, 1'b1);
        tick();
        chk_all("cnt_12", 8'h12, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        chk_all("mid_rst", 8'hA5, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_all("resume", 8'hA6, 1'b0, 1'b1);

        // reset overrides en=0
        en = 1'b0; rst = 1'b1; mode = 2'b11;
        tick();
        chk_all("rst_en0", 8'hA5, 1'b0, 1'b0);
        rst = 1'b0;

`ifdef JK_REG_BANK_TCNT_EN
        chk("tcnt_rst", {16'h0, tcnt}, 32'h0);
        en = 1'b1; mode = 2'b00; j = 8'h01; k = 8'h01;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        mode = 2'b01; d = 8'h00;
        tick();
        tick();
        chk("tcnt_5", {16'h0, tcnt}, 32'h5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of JK bit-cells (legal range 1..32).
REQ-002 Parameter RST_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 Port clk  input  1  rising-edge clock, the only clock.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port en  input  1  cycle enable; 0 holds all state.
REQ-006 Port mode  input  2  operation select: 00 JK, 01 LOAD, 10 COUNT, 11 SHIFT.
REQ-007 Port j  input  WIDTH  per-bit J.
REQ-008 Port k  input  WIDTH  per-bit K.
REQ-009 Port d  input  WIDTH  parallel load data.
REQ-010 Port si  input  1  serial-in for SHIFT mode.
REQ-011 Port q  output  WIDTH  registered state.
REQ-012 Port qb  output  WIDTH  bitwise complement of q, combinational.
REQ-013 Port co  output  1  registered carry-out, COUNT wrap indicator.
REQ-014 Port chg  output  1  registered flag: q changed on the previous edge.

Function
REQ-015 All state updates occur on the rising edge of clk; latency from inputs to q is one cycle.
REQ-016 en=0 (rst=0): q holds; co and chg are cleared to 0.
REQ-017 JK mode, per bit i: {j,k}=00 hold, 01 clear, 10 set, 11 toggle.
REQ-018 LOAD mode: q <= d; j and k are ignored.
REQ-019 COUNT mode: q <= q+1 modulo 2^WIDTH; j, k, d and si are ignored.
REQ-020 COUNT wrap: co=1 for exactly one cycle after the edge where q goes from all-ones to 0; otherwise co=0.
REQ-021 co SHALL be 0 in every mode other than COUNT.
REQ-022 SHIFT mode: q <= {q[WIDTH-2:0], si}; for WIDTH=1, q <= si.
REQ-023 chg SHALL be 1 for one cycle exactly when the new q differs from the old q, in any mode.
REQ-024 The JK toggle case (11) SHALL be a pure synchronous toggle with no oscillation or combinational feedback on q.
REQ-025 qb SHALL track q in the same cycle, including during reset.

Reset
REQ-026 rst=1 at a rising edge: q <= RST_VAL, co <= 0, chg <= 0, overriding en and mode.
REQ-027 Reset asserted mid-COUNT or mid-SHIFT SHALL take effect on the next edge; no partial update is applied.
REQ-028 Before the first reset edge, q is undefined; the bench SHALL apply reset before checking any output.

Configuration
REQ-029 Macro JK_REG_BANK_TCNT_EN: when defined, add output tcnt (16-bit, registered), counting edges on which at least one bit toggled in JK mode via {j,k}=11; reset to 0; saturates at 16'hFFFF.
REQ-030 Without JK_REG_BANK_TCNT_EN, tcnt and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 WIDTH=8, RST_VAL=8'hA5, rst=1 for one edge -> q=8'hA5, qb=8'h5A, co=0, chg=0.
REQ-032 JK mode, q=8'h00, j=8'hF0, k=8'h0F -> q=8'hF0, chg=1; then j=k=8'hFF -> q=8'h0F; then j=k=0 -> q holds, chg=0.
REQ-033 LOAD d=8'hFE, then COUNT for 2 edges -> q=8'hFF, then q=8'h00 with co=1 for one cycle; next COUNT edge -> q=8'h01, co=0.
REQ-034 SHIFT from q=8'h81 with si=1 -> q=8'h03; then si=0 -> q=8'h06; en=0 for 3 edges -> q stays 8'h06, chg=0.
REQ-035 COUNT from q=8'h10, rst=1 on the third edge -> q=RST_VAL, co=0, chg=0; counting resumes from RST_VAL after rst falls.
REQ-036 With JK_REG_BANK_TCNT_EN defined: 5 JK edges with j=k=8'h01 plus 2 LOAD edges -> tcnt=5.
